// File: rtl/camera_fb_writer.sv
// Writes the camera RGB565 pixel stream into a double-buffered framebuffer, optionally 2x2
// decimated. Only complete, in-range frames swap the display bank.
module camera_fb_writer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned DECIMATE = 1,
    parameter int unsigned ADDR_W   = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_active,
    input  logic              i_valid,
    input  logic [15:0]       i_data,
    input  logic [9:0]        i_row,
    input  logic [9:0]        i_col,
    input  logic              i_freeze,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [15:0]       o_wdata,
    output logic              o_front_bank,
    output logic              o_frame_ready,
    output logic              o_frame_err,
    output logic [15:0]       o_frame_count
);

    localparam int unsigned IDX_W  = ADDR_W - 1;
    localparam int unsigned OUT_W  = (DECIMATE != 0) ? H_ACTIVE / 2 : H_ACTIVE;
    localparam int unsigned OUT_H  = (DECIMATE != 0) ? V_ACTIVE / 2 : V_ACTIVE;
    localparam int unsigned EXPECT = OUT_W * OUT_H;
    localparam logic [18:0] CNT_MAX = '1;

    typedef enum logic [2:0] {StIdle, StArm, StWrite, StDrain, StDone} state_e;

    state_e             state_q;
    logic               fa_q;
    logic               rise;
    logic               fall;
    logic               drain_q;
    logic               ovf_q;
    logic [18:0]        pix_cnt_q;
    logic [18:0]        pix_cnt_d;
    logic               in_range;
    logic               keep;
    logic               accept;
    logic               frame_ok;
    logic [9:0]         row_s;
    logic [9:0]         col_s;
    logic               s1_valid_q;
    logic [15:0]        s1_data_q;
    logic [9:0]         s1_col_q;
    logic [IDX_W-1:0]   s1_base_q;

    assign rise     = i_frame_active & ~fa_q;
    assign fall     = ~i_frame_active & fa_q;
    assign in_range = (32'(i_col) < H_ACTIVE) && (32'(i_row) < V_ACTIVE);
    assign keep     = (DECIMATE == 0) || !(i_row[0] | i_col[0]);
    assign accept   = (state_q == StWrite) && i_valid && in_range && keep;
    assign row_s    = (DECIMATE != 0) ? (i_row >> 1) : i_row;
    assign col_s    = (DECIMATE != 0) ? (i_col >> 1) : i_col;

    // Includes a write landing this cycle so the verdict can be registered at DONE entry.
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (o_we && (pix_cnt_q != CNT_MAX)) begin
            pix_cnt_d = pix_cnt_q + 19'd1;
        end
    end

    assign frame_ok = (32'(pix_cnt_d) == EXPECT) && !ovf_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_col_q   <= '0;
            s1_base_q  <= '0;
            o_we       <= 1'b0;
            o_addr     <= '0;
            o_wdata    <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_data_q <= i_data;
                s1_col_q  <= col_s;
                s1_base_q <= IDX_W'(row_s) * IDX_W'(OUT_W);
            end
            o_we <= s1_valid_q;
            if (s1_valid_q) begin
                o_addr  <= {~o_front_bank, s1_base_q + IDX_W'(s1_col_q)};
                o_wdata <= s1_data_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            fa_q          <= 1'b0;
            drain_q       <= 1'b0;
            ovf_q         <= 1'b0;
            pix_cnt_q     <= '0;
            o_front_bank  <= 1'b0;
            o_frame_ready <= 1'b0;
            o_frame_err   <= 1'b0;
            o_frame_count <= '0;
        end else begin
            fa_q          <= i_frame_active;
            pix_cnt_q     <= pix_cnt_d;
            o_frame_ready <= 1'b0;
            o_frame_err   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!i_frame_active) state_q <= StArm;
                end
                StArm: begin
                    if (rise && !i_freeze) begin
                        state_q   <= StWrite;
                        pix_cnt_q <= '0;
                        ovf_q     <= 1'b0;
                    end
                end
                StWrite: begin
                    if (i_valid && !in_range) ovf_q <= 1'b1;
                    if (fall) begin
                        state_q <= StDrain;
                        drain_q <= 1'b0;
                    end
                end
                StDrain: begin
                    drain_q <= 1'b1;
                    // Verdict pulses and the bank swap become visible during the DONE cycle.
                    if (drain_q) begin
                        state_q <= StDone;
                        if (frame_ok) begin
                            o_front_bank  <= ~o_front_bank;
                            o_frame_ready <= 1'b1;
                            o_frame_count <= o_frame_count + 16'd1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StArm;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_fb_writer.sv
// Drives two writers (full-res and decimated) with the same pixel stream and checks every
// output cycle against a frame-level reference model, plus a few hand-computed expectations.
module tb_camera_fb_writer;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 4;
    localparam int unsigned AW   = 18;
    localparam int          RING = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fa;
    logic          valid;
    logic          freeze;
    logic [15:0]   data;
    logic [9:0]    row;
    logic [9:0]    col;

    logic          we_o    [2];
    logic [AW-1:0] addr_o  [2];
    logic [15:0]   wdata_o [2];
    logic          bank_o  [2];
    logic          rdy_o   [2];
    logic          err_o   [2];
    logic [15:0]   cnt_o   [2];

    always #5 clk = ~clk;

    camera_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIMATE(0), .ADDR_W(AW)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_frame_active(fa), .i_valid(valid), .i_data(data),
        .i_row(row), .i_col(col), .i_freeze(freeze), .o_we(we_o[0]), .o_addr(addr_o[0]),
        .o_wdata(wdata_o[0]), .o_front_bank(bank_o[0]), .o_frame_ready(rdy_o[0]),
        .o_frame_err(err_o[0]), .o_frame_count(cnt_o[0])
    );

    camera_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIMATE(1), .ADDR_W(AW)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_frame_active(fa), .i_valid(valid), .i_data(data),
        .i_row(row), .i_col(col), .i_freeze(freeze), .o_we(we_o[1]), .o_addr(addr_o[1]),
        .o_wdata(wdata_o[1]), .o_front_bank(bank_o[1]), .o_frame_ready(rdy_o[1]),
        .o_frame_err(err_o[1]), .o_frame_count(cnt_o[1])
    );

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s dut%0d t=%0t: got 0x%0h, expected 0x%0h", name, d, $time, act, exp);
        end
    endtask

    // Reference model: frame-level rules, expectations scheduled into a ring by cycle number.
    int          cyc     = 0;
    bit          started = 1'b0;
    bit          prev_fa = 1'b0;
    int          mode     [2];  // 0 wait for low, 1 armed, 2 capturing, 3 finishing
    int          pcnt     [2];
    int          fall_cyc [2];
    bit          bad      [2];
    bit          m_bank   [2];
    int          m_count  [2];
    bit          r_we   [2][RING];
    logic [AW-1:0] r_addr [2][RING];
    logic [15:0] r_data [2][RING];
    bit          r_rdy  [2][RING];
    bit          r_err  [2][RING];
    bit          r_bank [2][RING];
    logic [15:0] r_cnt  [2][RING];

    function automatic int out_w(input int d);
        return (d != 0) ? H / 2 : H;
    endfunction

    function automatic int expect_pix(input int d);
        return (d != 0) ? (H / 2) * (V / 2) : H * V;
    endfunction

    always @(posedge clk) begin : model
        int n1;
        int n2;
        int idx;
        bit rise;
        bit fall;
        n1   = (cyc + 1) % RING;
        n2   = (cyc + 2) % RING;
        rise = fa && !prev_fa;
        fall = !fa && prev_fa;
        for (int d = 0; d < 2; d++) begin
            r_we[d][n2]  = 1'b0;
            r_rdy[d][n1] = 1'b0;
            r_err[d][n1] = 1'b0;
            if (rst) begin
                mode[d]    = 0;
                m_bank[d]  = 1'b0;
                m_count[d] = 0;
                r_we[d][n1] = 1'b0;
            end else begin
                case (mode[d])
                    0: if (!fa) mode[d] = 1;
                    1: if (rise && !freeze) begin
                        mode[d] = 2;
                        pcnt[d] = 0;
                        bad[d]  = 1'b0;
                    end
                    2: begin
                        if (valid) begin
                            if (int'(row) >= V || int'(col) >= H) begin
                                bad[d] = 1'b1;
                            end else if (d == 0 || (row % 2 == 0 && col % 2 == 0)) begin
                                idx = (d != 0) ? (int'(row) / 2) * out_w(d) + int'(col) / 2
                                               : int'(row) * out_w(d) + int'(col);
                                r_we[d][n2]   = 1'b1;
                                r_addr[d][n2] = {~m_bank[d], 17'(idx)};
                                r_data[d][n2] = data;
                                pcnt[d]++;
                            end
                        end
                        if (fall) begin
                            mode[d]     = 3;
                            fall_cyc[d] = cyc;
                        end
                    end
                    default: begin
                        if (cyc == fall_cyc[d] + 2) begin
                            if (pcnt[d] == expect_pix(d) && !bad[d]) begin
                                m_bank[d]    = !m_bank[d];
                                m_count[d]   = (m_count[d] + 1) % 65536;
                                r_rdy[d][n1] = 1'b1;
                            end else begin
                                r_err[d][n1] = 1'b1;
                            end
                        end
                        if (cyc == fall_cyc[d] + 3) mode[d] = 1;
                    end
                endcase
            end
            r_bank[d][n1] = m_bank[d];
            r_cnt[d][n1]  = 16'(m_count[d]);
        end
        if (rst) started = 1'b1;
        prev_fa = rst ? 1'b0 : fa;
        cyc++;
    end

    always @(negedge clk) begin : compare
        int s;
        if (started) begin
            s = cyc % RING;
            for (int d = 0; d < 2; d++) begin
                check("we", d, 32'(we_o[d]), 32'(r_we[d][s]));
                if (r_we[d][s]) begin
                    check("addr", d, 32'(addr_o[d]), 32'(r_addr[d][s]));
                    check("wdata", d, 32'(wdata_o[d]), 32'(r_data[d][s]));
                end
                check("frame_ready", d, 32'(rdy_o[d]), 32'(r_rdy[d][s]));
                check("frame_err", d, 32'(err_o[d]), 32'(r_err[d][s]));
                check("front_bank", d, 32'(bank_o[d]), 32'(r_bank[d][s]));
                check("frame_count", d, 32'(cnt_o[d]), 32'(r_cnt[d][s]));
            end
        end
    end

    int          wr_cnt [2];
    logic [15:0] mem1 [64];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) if (we_o[d] === 1'b1) wr_cnt[d]++;
        if (we_o[1] === 1'b1 && addr_o[1][16:0] < 17'd64) mem1[addr_o[1][5:0]] = wdata_o[1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic frame(input int rows, input int cols, input bit rnd, input bit bad_px,
                         input bit merge);
        logic [35:0] q[$];
        logic [35:0] e;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                q.push_back({10'(r), 10'(c), rnd ? 16'($urandom) : 16'(r * 8 + c)});
            end
        end
        if (bad_px) q.push_back({10'd1, 10'd8, 16'hdead});
        fa = 1'b1;
        valid = 1'b0;
        tick();
        for (int i = 0; i < q.size(); i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                tick();
            end
            e = q[i];
            valid = 1'b1;
            row   = e[35:26];
            col   = e[25:16];
            data  = e[15:0];
            if (merge && i == q.size() - 1) fa = 1'b0;
            tick();
        end
        valid = 1'b0;
        fa    = 1'b0;
        tick();
    endtask

    // Positions the bench in the cycle where a non-merged frame's verdict is visible.
    task automatic to_verdict();
        tick();
        tick();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int w0;
        int w1;
        rst = 1'b1; fa = 1'b0; valid = 1'b0; freeze = 1'b0; data = '0; row = '0; col = '0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_bank", 0, 32'(bank_o[0]), 32'd0);
        check("reset_count", 0, 32'(cnt_o[0]), 32'd0);
        check("reset_we", 0, 32'(we_o[0]), 32'd0);
        idle(2);

        w0 = wr_cnt[0];
        frame(4, 8, 1'b0, 1'b0, 1'b0);
        to_verdict();
        check("f1_ready", 0, 32'(rdy_o[0]), 32'd1);
        check("f1_bank", 0, 32'(bank_o[0]), 32'd1);
        check("f1_count", 0, 32'(cnt_o[0]), 32'd1);
        check("f1_writes", 0, 32'(wr_cnt[0] - w0), 32'd32);
        idle(4);

        frame(4, 8, 1'b0, 1'b0, 1'b0);
        to_verdict();
        check("f2_bank", 0, 32'(bank_o[0]), 32'd0);
        check("f2_count", 0, 32'(cnt_o[0]), 32'd2);
        idle(4);

        frame(3, 8, 1'b1, 1'b0, 1'b0);
        to_verdict();
        check("short_err", 0, 32'(err_o[0]), 32'd1);
        check("short_bank", 0, 32'(bank_o[0]), 32'd0);
        idle(4);
        frame(4, 8, 1'b1, 1'b1, 1'b0);
        to_verdict();
        check("col8_err", 0, 32'(err_o[0]), 32'd1);
        check("col8_count", 0, 32'(cnt_o[0]), 32'd2);
        check("col8_err_dec", 1, 32'(err_o[1]), 32'd1);
        idle(4);

        w1 = wr_cnt[1];
        frame(4, 8, 1'b0, 1'b0, 1'b0);
        to_verdict();
        check("dec_ready", 1, 32'(rdy_o[1]), 32'd1);
        check("dec_writes", 1, 32'(wr_cnt[1] - w1), 32'd8);
        check("dec_idx5", 1, 32'(mem1[5]), 32'h12);
        check("dec_count", 1, 32'(cnt_o[1]), 32'd4);
        idle(4);

        freeze = 1'b1;
        w0 = wr_cnt[0];
        w1 = wr_cnt[1];
        frame(4, 8, 1'b1, 1'b0, 1'b0);
        to_verdict();
        freeze = 1'b0;
        check("frz_ready", 0, 32'(rdy_o[0]), 32'd0);
        check("frz_writes", 0, 32'(wr_cnt[0] - w0), 32'd0);
        check("frz_writes", 1, 32'(wr_cnt[1] - w1), 32'd0);
        idle(4);
        frame(4, 8, 1'b1, 1'b0, 1'b0);
        to_verdict();
        check("post_frz_ready", 0, 32'(rdy_o[0]), 32'd1);
        check("post_frz_count", 0, 32'(cnt_o[0]), 32'd4);
        idle(4);

        fa = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            valid = 1'b1;
            row = 10'(i / 8);
            col = 10'(i % 8);
            data = 16'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check("midrst_bank", 0, 32'(bank_o[0]), 32'd0);
        check("midrst_count", 0, 32'(cnt_o[0]), 32'd0);
        check("midrst_we", 0, 32'(we_o[0]), 32'd0);
        w0 = wr_cnt[0];
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1;
            row = 10'd0;
            col = 10'(i);
            tick();
        end
        idle(3);
        check("held_high_writes", 0, 32'(wr_cnt[0] - w0), 32'd0);
        fa = 1'b0;
        idle(4);
        frame(4, 8, 1'b1, 1'b0, 1'b0);
        to_verdict();
        check("after_rst_count", 0, 32'(cnt_o[0]), 32'd1);
        idle(4);

        repeat (16) begin
            freeze = ($urandom_range(0, 5) == 0);
            frame($urandom_range(2, 4), $urandom_range(7, 8), 1'b1, $urandom_range(0, 4) == 0,
                  1'(($urandom_range(0, 1))));
            freeze = 1'b0;
            idle($urandom_range(1, 6));
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
